// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
// Holds default XLEN/NUM_REGS, REG_ADDR_W and reg_addr_t.
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bundle: one write port, two read ports.
// master drives writeEn/addr1/addr2/addr3/writeData, slave returns rd1/rd2.
interface regfile_if #(
  parameter int XLEN   = regfile_pkg::XLEN,
  parameter int ADDR_W = regfile_pkg::REG_ADDR_W
);

  logic              writeEn;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
  logic [XLEN-1:0]   writeData;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;

  modport master (
    output writeEn, addr1, addr2, addr3, writeData,
    input  rd1, rd2
  );

  modport slave (
    input  writeEn, addr1, addr2, addr3, writeData,
    output rd1, rd2
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, x0 forced to zero and,
// with REGFILE_BYPASS_EN defined, same-cycle forwarding of the write.
// Ports: regs_i (storage), addr_i, byp_en_i/byp_addr_i/byp_data_i, rd_o.
module regfile_read_port #(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [XLEN-1:0]   regs_i [NUM_REGS],
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] byp_addr_i,
  input  logic [XLEN-1:0]   byp_data_i,
  output logic [XLEN-1:0]   rd_o
);

  import regfile_pkg::*;

  localparam logic [ADDR_W:0] NR = NUM_REGS[ADDR_W:0];

  logic addr_ok;

  assign addr_ok = (addr_i != '0) && ({1'b0, addr_i} < NR);

  always_comb begin
    rd_o = '0;
    if (addr_ok) begin
      rd_o = regs_i[addr_i];
    end
`ifdef REGFILE_BYPASS_EN
    // byp_en_i already excludes x0 and reset, so x0 stays zero
    if (byp_en_i && (addr_i == byp_addr_i)) begin
      rd_o = byp_data_i;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{byp_en_i, byp_addr_i, byp_data_i};
`endif

endmodule

// File: rtl/regfile.sv
// RV integer register file: 2 async read ports, 1 sync write port.
// Ports: clk, rst_n (async low), bus (regfile_if.slave). Macro: REGFILE_BYPASS_EN.
module regfile #(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input logic     clk,
  input logic     rst_n,
  regfile_if.slave bus
);

  import regfile_pkg::*;

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0] NR = NUM_REGS[ADDR_W:0];

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            we;
  logic            byp_en;

  // X/Z on writeEn yields an X here, which the if() below treats as off
  assign we = bus.writeEn
            & (bus.addr3 != '0)
            & ({1'b0, bus.addr3} < NR);

  // Forwarding is suppressed in reset so all reads stay zero
  assign byp_en = we & rst_n;

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[bus.addr3] = bus.writeData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_read_port #(
    .XLEN    (XLEN),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_rp1 (
    .regs_i    (regs_q),
    .addr_i    (bus.addr1),
    .byp_en_i  (byp_en),
    .byp_addr_i(bus.addr3),
    .byp_data_i(bus.writeData),
    .rd_o      (bus.rd1)
  );

  regfile_read_port #(
    .XLEN    (XLEN),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_rp2 (
    .regs_i    (regs_q),
    .addr_i    (bus.addr2),
    .byp_en_i  (byp_en),
    .byp_addr_i(bus.addr3),
    .byp_data_i(bus.writeData),
    .rd_o      (bus.rd2)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
// Expected values are hand-computed per scenario.
module tb_regfile;

  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_if bus ();

  regfile dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic wr(input reg_addr_t a, input logic [31:0] d);
    @(negedge clk);
    bus.writeEn   = 1'b1;
    bus.addr3     = a;
    bus.writeData = d;
    @(posedge clk);
    #1;
    bus.writeEn = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.writeEn = 1'b0;
    bus.addr1 = 5'd5;
    bus.addr2 = 5'd31;
    bus.addr3 = 5'd0;
    bus.writeData = '0;
    #12;
    total += 2;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL init_rd1 got=%h exp=0", bus.rd1);
    end
    if (bus.rd2 !== 32'h0) begin
      bad++; $display("FAIL init_rd2 got=%h exp=0", bus.rd2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr(5'd5, 32'h0000AAAA);
    wr(5'd31, 32'h0000BBBB);
    #1;
    total += 2;
    if (bus.rd1 !== 32'h0000AAAA) begin
      bad++; $display("FAIL pre_rst_x5 got=%h exp=0000aaaa", bus.rd1);
    end
    if (bus.rd2 !== 32'h0000BBBB) begin
      bad++; $display("FAIL pre_rst_x31 got=%h exp=0000bbbb", bus.rd2);
    end
    // mid-cycle async reset, no clock edge before checking
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total += 2;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL async_rst_rd1 got=%h exp=0", bus.rd1);
    end
    if (bus.rd2 !== 32'h0) begin
      bad++; $display("FAIL async_rst_rd2 got=%h exp=0", bus.rd2);
    end
    // write during reset must be lost
    bus.writeEn = 1'b1;
    bus.addr3 = 5'd6;
    bus.writeData = 32'h77;
    bus.addr1 = 5'd6;
    #1;
    total++;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL rst_read_x6 got=%h exp=0", bus.rd1);
    end
    @(posedge clk);
    @(negedge clk);
    bus.writeEn = 1'b0;
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL rst_write_lost got=%h exp=0", bus.rd1);
    end
    wr(5'd6, 32'h66);
    total++;
    if (bus.rd1 !== 32'h66) begin
      bad++; $display("FAIL first_write got=%h exp=66", bus.rd1);
    end
  endtask

  task automatic test_write_read;
    wr(5'd5, 32'hDEADBEEF);
    bus.addr1 = 5'd5;
    #1;
    total++;
    if (bus.rd1 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wr_rd_x5 got=%h exp=deadbeef", bus.rd1);
    end
  endtask

  task automatic test_x0;
    wr(5'd0, 32'h12345678);
    bus.addr1 = 5'd0;
    bus.addr2 = 5'd0;
    #1;
    total += 2;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL x0_rd1 got=%h exp=0", bus.rd1);
    end
    if (bus.rd2 !== 32'h0) begin
      bad++; $display("FAIL x0_rd2 got=%h exp=0", bus.rd2);
    end
  endtask

  task automatic test_enable;
    @(negedge clk);
    bus.writeEn = 1'b0;
    bus.addr3 = 5'd7;
    bus.writeData = 32'hFFFFFFFF;
    bus.addr1 = 5'd7;
    @(posedge clk);
    #1;
    total++;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL en_off_x7 got=%h exp=0", bus.rd1);
    end
  endtask

  task automatic test_dual_port;
    wr(5'd3, 32'hA5A5A5A5);
    wr(5'd4, 32'h5A5A5A5A);
    bus.addr1 = 5'd3;
    bus.addr2 = 5'd4;
    #1;
    total += 2;
    if (bus.rd1 !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL dp_rd1 got=%h exp=a5a5a5a5", bus.rd1);
    end
    if (bus.rd2 !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL dp_rd2 got=%h exp=5a5a5a5a", bus.rd2);
    end
    bus.addr1 = 5'd4;
    #1;
    total += 2;
    if (bus.rd1 !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL same_rd1 got=%h exp=5a5a5a5a", bus.rd1);
    end
    if (bus.rd2 !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL same_rd2 got=%h exp=5a5a5a5a", bus.rd2);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp;
    wr(5'd9, 32'h1);
    @(negedge clk);
    bus.writeEn = 1'b1;
    bus.addr3 = 5'd9;
    bus.writeData = 32'h2;
    bus.addr1 = 5'd9;
    bus.addr2 = 5'd0;
    #1;
    exp = BYP ? 32'h2 : 32'h1;
    total += 2;
    if (bus.rd1 !== exp) begin
      bad++; $display("FAIL byp_pre got=%h exp=%h", bus.rd1, exp);
    end
    if (bus.rd2 !== 32'h0) begin
      bad++; $display("FAIL byp_x0_rd2 got=%h exp=0", bus.rd2);
    end
    @(posedge clk);
    #1;
    bus.writeEn = 1'b0;
    total++;
    if (bus.rd1 !== 32'h2) begin
      bad++; $display("FAIL byp_post got=%h exp=2", bus.rd1);
    end
    @(negedge clk);
    bus.writeEn = 1'b1;
    bus.addr3 = 5'd0;
    bus.writeData = 32'h55;
    bus.addr1 = 5'd0;
    #1;
    total++;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL byp_x0 got=%h exp=0", bus.rd1);
    end
    @(posedge clk);
    #1;
    bus.writeEn = 1'b0;
  endtask

  task automatic test_x_enable;
    @(negedge clk);
    bus.writeEn = 1'bx;
    bus.addr3 = 5'd10;
    bus.writeData = 32'h0000CAFE;
    bus.addr1 = 5'd10;
    #1;
    total++;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL xen_pre got=%h exp=0", bus.rd1);
    end
    @(posedge clk);
    #1;
    bus.writeEn = 1'b0;
    #1;
    total++;
    if (bus.rd1 !== 32'h0) begin
      bad++; $display("FAIL xen_post got=%h exp=0", bus.rd1);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.writeEn = 1'b1;
    bus.addr3 = 5'd11;
    bus.writeData = 32'h11111111;
    @(negedge clk);
    bus.addr3 = 5'd12;
    bus.writeData = 32'h22222222;
    @(negedge clk);
    bus.addr3 = 5'd13;
    bus.writeData = 32'h33333333;
    @(negedge clk);
    bus.writeEn = 1'b0;
    bus.addr1 = 5'd11;
    bus.addr2 = 5'd12;
    #1;
    total += 2;
    if (bus.rd1 !== 32'h11111111) begin
      bad++; $display("FAIL b2b_x11 got=%h exp=11111111", bus.rd1);
    end
    if (bus.rd2 !== 32'h22222222) begin
      bad++; $display("FAIL b2b_x12 got=%h exp=22222222", bus.rd2);
    end
    bus.addr1 = 5'd13;
    bus.addr2 = 5'd5;
    #1;
    total += 2;
    if (bus.rd1 !== 32'h33333333) begin
      bad++; $display("FAIL b2b_x13 got=%h exp=33333333", bus.rd1);
    end
    if (bus.rd2 !== 32'hDEADBEEF) begin
      bad++; $display("FAIL b2b_x5 got=%h exp=deadbeef", bus.rd2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_enable();
    test_dual_port();
    test_bypass();
    test_x_enable();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL provide parameter XLEN, default 32, meaning data width of every register and data port.
REQ-002 The block SHALL provide parameter NUM_REGS, default 32, meaning register count; address width is clog2(NUM_REGS), 5 at default.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all writes.
REQ-005 rst_n  input  1  asynchronous active-low reset of all registers.
REQ-006 writeEn  input  1  write enable for the write port.
REQ-007 addr1  input  5  read address, port 1 (rs1).
REQ-008 addr2  input  5  read address, port 2 (rs2).
REQ-009 addr3  input  5  write address (rd).
REQ-010 writeData  input  XLEN  write data.
REQ-011 rd1  output  XLEN  read data, port 1.
REQ-012 rd2  output  XLEN  read data, port 2.

Function
REQ-013 Storage SHALL be NUM_REGS registers of XLEN bits, x0..x31.
REQ-014 Reads SHALL be combinational, with zero-cycle latency: rd1 = x[addr1], rd2 = x[addr2].
REQ-015 Writes SHALL occur on rising clk when writeEn=1 and rst_n=1: x[addr3] <= writeData.
REQ-016 x0 SHALL read 0 at all times; writes to addr3=0 SHALL be discarded.
REQ-017 Without bypass, a same-cycle read of addr3 SHALL return the old value; the new value SHALL appear after the clock edge.
REQ-018 With writeEn=0, no register SHALL change.
REQ-019 addr1=addr2 SHALL return identical data on both ports.
REQ-020 X or Z on writeEn SHALL be treated as a write-disable.

Reset
REQ-021 rst_n=0 SHALL clear all registers to 0 immediately, without waiting for a clock edge.
REQ-022 rd1 and rd2 SHALL read 0 for every address during reset.
REQ-023 A write coinciding with reset assertion SHALL be lost.
REQ-024 The first write after rst_n rises SHALL take effect on the first rising clk edge with writeEn=1.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-026 With REGFILE_BYPASS_EN defined: if writeEn=1, addr3!=0 and addrN=addr3, then rdN SHALL equal writeData in the same cycle.
REQ-027 Without REGFILE_BYPASS_EN, REQ-017 SHALL apply.
REQ-028 x0 SHALL read 0 in both configurations.

Structure
REQ-029 Package regfile_pkg SHALL hold XLEN, NUM_REGS, REG_ADDR_W and type reg_addr_t; the module SHALL import it.
REQ-030 Sub-module regfile_read_port (address decode/mux, x0 zeroing, optional bypass) SHALL be instantiated twice, once per read port.
REQ-031 The storage array and write logic SHALL reside in regfile itself.

Verification
REQ-032 Reset: rst_n=0 mid-cycle -> rd1=rd2=0 for addr1=5, addr2=31 without a clock edge.
REQ-033 Write/read: writeEn=1, addr3=5, writeData=0xDEADBEEF, one edge; then addr1=5 -> rd1=0xDEADBEEF.
REQ-034 x0: write 0x12345678 to addr3=0 -> rd1 and rd2 at addr 0 read 0x00000000.
REQ-035 Enable: writeEn=0, addr3=7, writeData=0xFFFFFFFF -> x7 keeps its prior value, 0x00000000 after reset.
REQ-036 Dual port: x3=0xA5A5A5A5, x4=0x5A5A5A5A, addr1=3, addr2=4 -> rd1=0xA5A5A5A5, rd2=0x5A5A5A5A; addr1=addr2=4 -> both 0x5A5A5A5A.
REQ-037 Bypass: x9=0x1, then same-cycle write of 0x2 to 9 with addr1=9 -> rd1=0x2 before the edge if REGFILE_BYPASS_EN, else 0x1; rd1=0x2 after the edge in both configurations.
